// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the round-robin N:1 multiplexer slice.
//   MUX_NUM_CH_DEF     : default number of input channels
//   MUX_DATA_WIDTH_DEF : default bits per channel word
//   out_state_t        : output register occupancy (EMPTY / FULL)
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam int MUX_NUM_CH_DEF     = 16;
  localparam int MUX_DATA_WIDTH_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage : mux_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority search: returns the first requesting index
// at or above ptr, wrapping from NUM_CH-1 back to 0.
//   req         : request vector, one bit per channel
//   ptr         : highest-priority index this cycle (always < NUM_CH)
//   grant       : index of the winning request (0 when none)
//   grant_valid : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH    = MUX_NUM_CH_DEF,
  parameter int SEL_WIDTH = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]    req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] grant,
  output logic                 grant_valid
);

  // Two descending passes so the last hit is the lowest index. The first pass
  // finds the lowest request overall (the wrapped-around winner); the second
  // overrides it with the lowest request at or above ptr, if there is one.
  always_comb begin
    // NOTE: every output gets a default before the loops; a path that leaves
    // a combinational output unassigned would infer a latch.
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant       = SEL_WIDTH'(i);
        grant_valid = 1'b1;
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        grant = SEL_WIDTH'(i);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/mux_rr_nx1.sv
// -----------------------------------------------------------------------------
// mux_rr_nx1
// Round-robin N:1 multiplexer with a single registered output stage and
// valid/ready handshakes on both sides.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : per-channel word valid
//   in_data   : flattened words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready  : one-hot (or zero) accept strobe, combinational
//   out_valid : registered output word valid
//   out_data  : registered selected word
//   out_sel   : index of the channel that supplied out_data
//   out_ready : downstream accept
// Optional build macro MUX_MANUAL_SEL_EN adds:
//   man_en    : restrict eligibility to a single channel
//   man_sel   : the channel allowed while man_en = 1 (>= NUM_CH grants nothing)
// -----------------------------------------------------------------------------
module mux_rr_nx1
  import mux_pkg::*;
#(
  parameter int NUM_CH     = MUX_NUM_CH_DEF,
  parameter int DATA_WIDTH = MUX_DATA_WIDTH_DEF,
  parameter int SEL_WIDTH  = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_WIDTH-1:0]         out_sel,
  input  logic                         out_ready
`ifdef MUX_MANUAL_SEL_EN
  ,
  input  logic                         man_en,
  input  logic [SEL_WIDTH-1:0]         man_sel
`endif
);

  out_state_t             state;
  logic [SEL_WIDTH-1:0]   rr_ptr;
  logic [SEL_WIDTH-1:0]   grant;
  logic [SEL_WIDTH-1:0]   next_ptr;
  logic                   grant_valid;
  logic                   load_en;
  logic                   grant_fire;
  logic [NUM_CH-1:0]      eligible;
  logic [DATA_WIDTH-1:0]  grant_word;

  assign out_valid = (state == FULL);

  // The output register can take a new word when it is empty or is being
  // drained this very cycle.
  assign load_en = !out_valid || out_ready;

`ifdef MUX_MANUAL_SEL_EN
  // Manual mode masks every channel but man_sel; an out-of-range man_sel
  // matches no channel, so nothing is granted.
  always_comb begin
    eligible = in_valid;
    if (man_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        eligible[i] = in_valid[i] && (int'(man_sel) == i);
      end
    end
  end
`else
  assign eligible = in_valid;
`endif

  rr_arbiter #(
    .NUM_CH    (NUM_CH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_arbiter (
    .req         (eligible),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // No accept strobe during reset: the register is being cleared, so a word
  // taken now would be lost.
  assign grant_fire = load_en && grant_valid && !rst;

  always_comb begin
    in_ready   = '0;
    grant_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(grant) == i) begin
        grant_word  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        in_ready[i] = grant_fire;
      end
    end
  end

  // Explicit wrap so non-power-of-2 channel counts never point past NUM_CH-1.
  assign next_ptr = (int'(grant) == NUM_CH - 1) ? '0 : grant + SEL_WIDTH'(1);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      rr_ptr   <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        state    <= FULL;
        out_data <= grant_word;
        out_sel  <= grant;
        rr_ptr   <= next_ptr;
      end else begin
        // Drained with nothing to replace it: data, index and pointer hold.
        state <= EMPTY;
      end
    end
  end

endmodule : mux_rr_nx1
